// File: rtl/psum_mux_acc_pkg.sv
// Shared defaults, FSM encoding and small helpers for the psum mux/accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package psum_mux_acc_pkg;

    localparam int NUM_MAC_DEF     = 3;
    localparam int PSUM_ADDR_WIDTH = 4;
    localparam int DEPTH_DEF       = 16;
    localparam int PSUM_WIDTH_DEF  = 24;
    localparam int ACC_WIDTH_DEF   = 28;

    // ACC: accumulate lane psums; FLUSH: keep accumulating until lanes are idle
    // and the pipeline is empty; DRAIN: stream the array out to GLB.
    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Width of a lane index/pointer; at least one bit even for a single lane.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/psum_mux_acc_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at/after the pointer.
// Latency: grant is combinational; pointer advances on the clock after a grant.
// Backpressure: en_i low suppresses all grants and freezes the pointer.
module psum_mux_acc_rr_arbiter
    import psum_mux_acc_pkg::*;
#(
    parameter int N = NUM_MAC_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en_i,
    input  logic [N-1:0]              req_i,
    output logic [N-1:0]              gnt_o,
    output logic                      gnt_vld_o,
    output logic [ptr_width(N)-1:0]   gnt_idx_o
);

    localparam int PW = ptr_width(N);
    localparam logic [PW:0] N_W = (PW + 1)'(N);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW:0]   cand;
    logic [PW:0]   nxt;

    // Search from the pointer upward with wrap; the first requester wins.
    always_comb begin
        gnt_o     = '0;
        gnt_vld_o = 1'b0;
        gnt_idx_o = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (PW + 1)'(k);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            if (en_i && !gnt_vld_o && req_i[cand[PW-1:0]]) begin
                gnt_vld_o             = 1'b1;
                gnt_o[cand[PW-1:0]]   = 1'b1;
                gnt_idx_o             = cand[PW-1:0];
            end
        end
    end

    // Pointer moves to the lane just after the winner so it goes last next time.
    always_comb begin
        ptr_d = ptr_q;
        nxt   = {1'b0, gnt_idx_o} + 1'b1;
        if (gnt_vld_o) begin
            ptr_d = (nxt >= N_W) ? '0 : nxt[PW-1:0];
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/psum_mux_acc.sv
// Psum mux/accumulator: RR-arbitrates MAC lanes into a signed psum array, drains the row to GLB.
// Latency: grant same cycle as Val, array updated 2 cycles later; drain streams 1 word/cycle, no bubbles.
// Backpressure: Rdy is the lane grant (none during DRAIN); drain word held while GLBMUX_Rdy low. Option: PSUM_SAT_EN.
module psum_mux_acc
    import psum_mux_acc_pkg::*;
#(
    parameter int NUM_MAC    = NUM_MAC_DEF,
    parameter int ADDR_WIDTH = PSUM_ADDR_WIDTH,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int PSUM_WIDTH = PSUM_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_MAC-1:0]             MACMUX_Val,
    input  logic [NUM_MAC*ADDR_WIDTH-1:0]  MACMUX_Addr,
    input  logic [NUM_MAC*PSUM_WIDTH-1:0]  MACMUX_Psum,
    input  logic [NUM_MAC-1:0]             MACMUX_Empty,
    output logic [NUM_MAC-1:0]             MUXMAC_Rdy,
    input  logic                           PEBMUX_Drain,
    output logic                           MUXGLB_Val,
    output logic [ADDR_WIDTH-1:0]          MUXGLB_Addr,
    output logic [ACC_WIDTH-1:0]           MUXGLB_Psum,
    input  logic                           GLBMUX_Rdy,
    output logic                           MUX_DrainDone,
    output logic                           MUX_Ovf
);

    localparam int PTR_W = ptr_width(NUM_MAC);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_e                        state_q;
    logic                          drain_req_q;
    logic                          glb_vld_q;
    logic [ADDR_WIDTH-1:0]         glb_addr_q;
    logic signed [ACC_WIDTH-1:0]   glb_psum_q;
    logic                          done_q;

    logic                          s1_vld_q;
    logic [ADDR_WIDTH-1:0]         s1_addr_q;
    logic signed [ACC_WIDTH-1:0]   s1_psum_q;

    logic signed [ACC_WIDTH-1:0]   acc_mem_q [DEPTH];

    logic [NUM_MAC-1:0]            gnt;
    logic                          gnt_vld;
    logic [PTR_W-1:0]              gnt_idx;
    logic                          grant_en;
    logic [ADDR_WIDTH-1:0]         lane_addr;
    logic signed [PSUM_WIDTH-1:0]  lane_psum;
    logic                          addr_ok;
    logic                          flush_clear;
    logic                          glb_hs;
    logic [ADDR_WIDTH-1:0]         next_addr;
    logic signed [ACC_WIDTH-1:0]   acc_old;
    logic signed [ACC_WIDTH-1:0]   acc_new;

    // ------------------------------------------------------------------
    // Arbitration: lanes are granted in ACC and FLUSH; DRAIN owns the array.
    // ------------------------------------------------------------------
    assign grant_en = rst_n && (state_q != ST_DRAIN);

    psum_mux_acc_rr_arbiter #(
        .N (NUM_MAC)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (grant_en),
        .req_i     (MACMUX_Val),
        .gnt_o     (gnt),
        .gnt_vld_o (gnt_vld),
        .gnt_idx_o (gnt_idx)
    );

    assign MUXMAC_Rdy = gnt;
    assign lane_addr  = MACMUX_Addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign lane_psum  = MACMUX_Psum[gnt_idx*PSUM_WIDTH +: PSUM_WIDTH];

    // Out-of-range addresses are still granted (the lane must not stall) but
    // never reach the array. With a fully populated address space every
    // address is valid.
    generate
        if (DEPTH < (1 << ADDR_WIDTH)) begin : g_addr_rng
            assign addr_ok = ({1'b0, lane_addr} < (ADDR_WIDTH + 1)'(DEPTH));
        end else begin : g_addr_full
            assign addr_ok = 1'b1;
        end
    endgenerate

    // FLUSH may only hand over to DRAIN once no lane can still produce a
    // psum and the last granted psum has been written into the array.
    assign flush_clear = (&MACMUX_Empty) && !(|MACMUX_Val) && !s1_vld_q;
    assign glb_hs      = (state_q == ST_DRAIN) && glb_vld_q && GLBMUX_Rdy;
    assign next_addr   = glb_addr_q + 1'b1;

    // ------------------------------------------------------------------
    // Accumulate adder: wrap by default, clamp to the signed range when
    // PSUM_SAT_EN is defined.
    // ------------------------------------------------------------------
    assign acc_old = acc_mem_q[s1_addr_q];

`ifdef PSUM_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH - 1){1'b0}}};

    logic signed [ACC_WIDTH:0] acc_wide;
    logic                      sat_ovf;
    logic                      sat_hit;
    logic                      ovf_q;

    assign acc_wide = (ACC_WIDTH + 1)'(acc_old) + (ACC_WIDTH + 1)'(s1_psum_q);
    assign sat_ovf  = acc_wide[ACC_WIDTH] ^ acc_wide[ACC_WIDTH-1];
    assign acc_new  = !sat_ovf ? acc_wide[ACC_WIDTH-1:0]
                               : (acc_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX);
    assign sat_hit  = s1_vld_q && sat_ovf;

    // Sticky overflow: any clamp sets it, the end of a drain clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (sat_hit) begin
            ovf_q <= 1'b1;
        end else if (done_q) begin
            ovf_q <= 1'b0;
        end
    end

    assign MUX_Ovf = ovf_q;
`else
    assign acc_new = acc_old + s1_psum_q;
    assign MUX_Ovf = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Stage 1: capture the granted psum, sign-extended to accumulator width.
    // ------------------------------------------------------------------
    // Pipeline register between the grant and the array update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_addr_q <= '0;
            s1_psum_q <= '0;
        end else begin
            s1_vld_q  <= gnt_vld && addr_ok;
            s1_addr_q <= lane_addr;
            s1_psum_q <= ACC_WIDTH'(lane_psum);
        end
    end

    // Array: read-add-write of one entry per cycle, cleared entry by entry as
    // the drain hands words to GLB. The two never overlap: DRAIN is only
    // entered with stage 1 empty and grants are blocked while draining.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                acc_mem_q[i] <= '0;
            end
        end else begin
            if (s1_vld_q) begin
                acc_mem_q[s1_addr_q] <= acc_new;
            end
            if (glb_hs) begin
                acc_mem_q[glb_addr_q] <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered drain outputs.
    // ------------------------------------------------------------------
    // The drain request latch is re-armed on entry to DRAIN, so any request
    // arriving while the current row streams out is kept for the next row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            drain_req_q <= 1'b0;
            glb_vld_q   <= 1'b0;
            glb_addr_q  <= '0;
            glb_psum_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (PEBMUX_Drain) begin
                drain_req_q <= 1'b1;
            end
            case (state_q)
                ST_ACC: begin
                    if (drain_req_q) begin
                        state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (flush_clear) begin
                        state_q     <= ST_DRAIN;
                        drain_req_q <= PEBMUX_Drain;
                        glb_vld_q   <= 1'b1;
                        glb_addr_q  <= '0;
                        glb_psum_q  <= acc_mem_q[0];
                    end
                end
                ST_DRAIN: begin
                    if (glb_hs) begin
                        if (glb_addr_q == LAST_ADDR) begin
                            state_q    <= ST_ACC;
                            glb_vld_q  <= 1'b0;
                            glb_addr_q <= '0;
                            glb_psum_q <= '0;
                            done_q     <= 1'b1;
                        end else begin
                            glb_addr_q <= next_addr;
                            glb_psum_q <= acc_mem_q[next_addr];
                        end
                    end
                end
                default: begin
                    state_q <= ST_ACC;
                end
            endcase
        end
    end

    assign MUXGLB_Val    = glb_vld_q;
    assign MUXGLB_Addr   = glb_addr_q;
    assign MUXGLB_Psum   = glb_psum_q;
    assign MUX_DrainDone = done_q;

endmodule
